// File: rtl/shared_reg_rr_arbiter_pkg.sv
// Shared constants and encodings for the arbiter and the output-register datapath.
// Latency: none (package only).
// Backpressure: not applicable.
package shared_reg_rr_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Payload width: 2**log_width + 1
  function automatic int calc_dw(input int log_width);
    return (1 << log_width) + 1;
  endfunction

  // Reset value of the datapath register, built from the same chain the datapath uses
  function automatic int calc_reset_value(input int log_width);
    int width;
    int width2;
    int width3;
    width  = (1 << log_width) - 1;
    width2 = width * 2;
    width3 = width2 + 1;
    return width3 + 1;
  endfunction

  // Source-index width; at least one bit even for a single requester
  function automatic int calc_src_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_rr_arbiter_rr_pick.sv
// Round-robin picker: first set request bit scanning cyclically from the pointer.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is registered.
module shared_reg_rr_arbiter_rr_pick
  import shared_reg_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = calc_src_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SRC_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_pick,
  output logic               o_any
);

  // Scan offsets 0..NUM_REQ-1 from the pointer and keep only the first hit
  always_comb begin
    o_pick = '0;
    o_any  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!o_any && (j == ((int'(i_ptr) + k) % NUM_REQ)) && i_req[j]) begin
          o_pick[j] = 1'b1;
          o_any     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shared_reg_rr_arbiter.sv
// Round-robin burst arbiter feeding one shared output register with valid/ready.
// Latency: grant one edge after a request is seen in IDLE; first beat one edge later.
// Backpressure: req_ready drops whenever the output register is full and not drained.
module shared_reg_rr_arbiter
  import shared_reg_rr_arbiter_pkg::*;
#(
  parameter int  LOG_WIDTH = 3,
  parameter int  NUM_REQ   = 4,
  parameter int  MAX_BURST = 8,
  localparam int DW        = calc_dw(LOG_WIDTH),
  localparam int SRC_W     = calc_src_w(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  output logic [SRC_W-1:0]      out_src,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam int            CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [DW-1:0] RST_DAT = DW'(calc_reset_value(LOG_WIDTH));
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [SRC_W-1:0]   r_ptr;
  logic [SRC_W-1:0]   w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;

  logic               r_out_vld;
  logic [DW-1:0]      r_out_dat;
  logic [SRC_W-1:0]   r_out_src;
  logic               r_out_last;

  logic [NUM_REQ-1:0] w_pick;
  logic               w_any;
  logic               w_space;
  logic               w_accept;
  logic               w_release;
  logic [SRC_W-1:0]   w_gidx;
  logic [DW-1:0]      w_sel_dat;
  logic               w_sel_last;

  shared_reg_rr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  // The output register can take a beat when empty or draining this cycle
  assign w_space   = !r_out_vld || out_ready;
  // Ready depends only on registered state so it never loops back through req_valid
  assign req_ready = ((r_state == BURST) && w_space) ? r_grant : '0;
  assign w_accept  = |(req_valid & req_ready);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_release = w_accept && (w_sel_last || (w_cnt_inc == CNT_MAX));

  // Decode the one-hot grant into an index and select that requester's beat
  always_comb begin
    w_gidx     = '0;
    w_sel_dat  = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_gidx     = SRC_W'(i);
        w_sel_dat  = req_data[i*DW +: DW];
        w_sel_last = req_last[i];
      end
    end
  end

  // Next-state logic: grant in IDLE, count beats and release in BURST
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_state_nxt = BURST;
          w_cnt_nxt   = '0;
        end
      end
      BURST: begin
        if (w_release) begin
          w_grant_nxt = '0;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + 1'b1;
        end else if (w_accept) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output register: load on accept, otherwise only the valid flag drains
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_vld  <= 1'b0;
      r_out_dat  <= RST_DAT;
      r_out_src  <= '0;
      r_out_last <= 1'b0;
    end else if (w_accept) begin
      r_out_vld  <= 1'b1;
      r_out_dat  <= w_sel_dat;
      r_out_src  <= w_gidx;
      r_out_last <= w_sel_last;
    end else if (out_ready) begin
      r_out_vld  <= 1'b0;
    end
  end

  assign grant     = r_grant;
  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign out_src   = r_out_src;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_shared_reg_rr_arbiter.sv
// Directed bench for the round-robin burst arbiter.
// Drives inputs 1ns after each rising edge and checks outputs at the same point.
// Expected values are hand-derived constants per scenario.
module tb_shared_reg_rr_arbiter;

  localparam int NR = 4;
  localparam int DW = 9;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_last;
  logic            out_ready;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  shared_reg_rr_arbiter #(
    .LOG_WIDTH (3),
    .NUM_REQ   (NR),
    .MAX_BURST (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] d, input logic l);
    req_valid[i]         = 1'b1;
    req_data[i*DW +: DW] = d;
    req_last[i]          = l;
  endtask

  task automatic drop_req(input int i);
    req_valid[i] = 1'b0;
    req_last[i]  = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    n_total++; if (out_data !== 9'd16) $display("FAIL rst_data got %0d exp 16", out_data); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if (grant !== 4'b0000) $display("FAIL rst_grant got %b exp 0000", grant); else n_pass++;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL rst_ready got %b exp 0000", req_ready); else n_pass++;
    n_total++; if ({out_src, out_last} !== 3'b000) $display("FAIL rst_src_last got %b exp 000", {out_src, out_last}); else n_pass++;
    tick();
    n_total++; if (grant !== 4'b0000) $display("FAIL idle_grant got %b exp 0000", grant); else n_pass++;
  endtask

  task automatic test_single_burst();
    set_req(2, 9'h101, 1'b0);
    tick();
    n_total++; if (grant !== 4'b0100) $display("FAIL sb_grant got %b exp 0100", grant); else n_pass++;
    n_total++; if (req_ready !== 4'b0100) $display("FAIL sb_ready got %b exp 0100", req_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL sb_valid0 got %b exp 0", out_valid); else n_pass++;
    tick();
    n_total++; if ({out_valid, out_data, out_src, out_last} !== {1'b1, 9'h101, 2'd2, 1'b0})
      $display("FAIL sb_beat1 got v%b d%h s%0d l%b exp v1 d101 s2 l0", out_valid, out_data, out_src, out_last); else n_pass++;
    set_req(2, 9'h0AA, 1'b0);
    tick();
    n_total++; if ({out_valid, out_data, out_src, out_last} !== {1'b1, 9'h0AA, 2'd2, 1'b0})
      $display("FAIL sb_beat2 got v%b d%h s%0d l%b exp v1 d0aa s2 l0", out_valid, out_data, out_src, out_last); else n_pass++;
    set_req(2, 9'h1FF, 1'b1);
    tick();
    n_total++; if ({out_valid, out_data, out_src, out_last} !== {1'b1, 9'h1FF, 2'd2, 1'b1})
      $display("FAIL sb_beat3 got v%b d%h s%0d l%b exp v1 d1ff s2 l1", out_valid, out_data, out_src, out_last); else n_pass++;
    n_total++; if (grant !== 4'b0000) $display("FAIL sb_release got %b exp 0000", grant); else n_pass++;
    drop_req(2);
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL sb_drain got %b exp 0", out_valid); else n_pass++;
  endtask

  // Pointer is 3 on entry, so requester 0 wins first
  task automatic test_round_robin();
    set_req(0, 9'h010, 1'b1);
    set_req(1, 9'h011, 1'b1);
    for (int k = 0; k < 4; k++) begin
      logic [NR-1:0] eg;
      logic [DW-1:0] ed;
      eg = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      ed = (k % 2 == 0) ? 9'h010 : 9'h011;
      tick();
      n_total++; if (grant !== eg) $display("FAIL rr_grant%0d got %b exp %b", k, grant, eg); else n_pass++;
      if (k > 0) begin
        n_total++; if (out_valid !== 1'b0) $display("FAIL rr_bubble%0d got %b exp 0", k, out_valid); else n_pass++;
      end
      tick();
      n_total++; if ({out_valid, out_data, out_src} !== {1'b1, ed, SW'(k % 2)})
        $display("FAIL rr_beat%0d got v%b d%h s%0d exp v1 d%h s%0d", k, out_valid, out_data, out_src, ed, k % 2); else n_pass++;
      n_total++; if (grant !== 4'b0000) $display("FAIL rr_rel%0d got %b exp 0000", k, grant); else n_pass++;
    end
    drop_req(0);
    drop_req(1);
    tick();
  endtask

  // Pointer is 2 on entry; requester 3 is the only one asking
  task automatic test_backpressure();
    set_req(3, 9'h030, 1'b0);
    tick();
    n_total++; if (grant !== 4'b1000) $display("FAIL bp_grant got %b exp 1000", grant); else n_pass++;
    tick();
    n_total++; if (out_data !== 9'h030) $display("FAIL bp_beat0 got %h exp 030", out_data); else n_pass++;
    set_req(3, 9'h031, 1'b0);
    out_ready = 1'b0;
    #1;
    n_total++; if (req_ready !== 4'b0000) $display("FAIL bp_ready_low got %b exp 0000", req_ready); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++; if ({out_valid, out_data, req_ready} !== {1'b1, 9'h030, 4'b0000})
        $display("FAIL bp_hold%0d got v%b d%h r%b exp v1 d030 r0000", c, out_valid, out_data, req_ready); else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_total++; if (req_ready !== 4'b1000) $display("FAIL bp_ready_resume got %b exp 1000", req_ready); else n_pass++;
    tick();
    n_total++; if (out_data !== 9'h031) $display("FAIL bp_beat1 got %h exp 031", out_data); else n_pass++;
    set_req(3, 9'h032, 1'b0);
    tick();
    n_total++; if (out_data !== 9'h032) $display("FAIL bp_beat2 got %h exp 032", out_data); else n_pass++;
    set_req(3, 9'h033, 1'b1);
    tick();
    n_total++; if ({out_data, out_last, grant} !== {9'h033, 1'b1, 4'b0000})
      $display("FAIL bp_beat3 got d%h l%b g%b exp d033 l1 g0000", out_data, out_last, grant); else n_pass++;
    drop_req(3);
    tick();
  endtask

  // Ten-beat burst splits at the eighth beat and re-arbitrates for the rest
  task automatic test_max_burst();
    set_req(3, 9'h101, 1'b0);
    tick();
    n_total++; if (grant !== 4'b1000) $display("FAIL mb_grant got %b exp 1000", grant); else n_pass++;
    for (int k = 1; k <= 10; k++) begin
      logic [DW-1:0] ed;
      ed = DW'(256 + k);
      tick();
      n_total++; if ({out_valid, out_data, out_last} !== {1'b1, ed, (k == 10)})
        $display("FAIL mb_beat%0d got v%b d%h l%b exp v1 d%h l%b", k, out_valid, out_data, out_last, ed, (k == 10)); else n_pass++;
      if (k == 8) begin
        n_total++; if (grant !== 4'b0000) $display("FAIL mb_forced_rel got %b exp 0000", grant); else n_pass++;
      end
      if (k < 10) set_req(3, DW'(256 + k + 1), (k + 1 == 10));
      else drop_req(3);
      if (k == 8) begin
        tick();
        n_total++; if ({grant, out_valid} !== {4'b1000, 1'b0})
          $display("FAIL mb_regrant got g%b v%b exp g1000 v0", grant, out_valid); else n_pass++;
      end
    end
    n_total++; if (grant !== 4'b0000) $display("FAIL mb_final_rel got %b exp 0000", grant); else n_pass++;
    tick();
  endtask

  // Last flag on the eighth beat: one release, no re-grant afterwards
  task automatic test_last_at_max();
    set_req(1, 9'h041, 1'b0);
    tick();
    n_total++; if (grant !== 4'b0010) $display("FAIL lm_grant got %b exp 0010", grant); else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_total++; if ({out_data, out_last} !== {DW'(64 + k), (k == 8)})
        $display("FAIL lm_beat%0d got d%h l%b exp d%h l%b", k, out_data, out_last, DW'(64 + k), (k == 8)); else n_pass++;
      if (k < 8) set_req(1, DW'(64 + k + 1), (k + 1 == 8));
      else drop_req(1);
    end
    n_total++; if (grant !== 4'b0000) $display("FAIL lm_rel got %b exp 0000", grant); else n_pass++;
    tick();
    n_total++; if ({grant, out_valid} !== {4'b0000, 1'b0})
      $display("FAIL lm_idle got g%b v%b exp g0000 v0", grant, out_valid); else n_pass++;
  endtask

  // Pointer is 2 before reset; afterwards req 0 must beat the waiting req 2
  task automatic test_reset_mid_burst();
    set_req(2, 9'h201, 1'b0);
    tick();
    n_total++; if (grant !== 4'b0100) $display("FAIL rm_grant got %b exp 0100", grant); else n_pass++;
    tick();
    set_req(2, 9'h202, 1'b0);
    tick();
    n_total++; if (out_data !== 9'h202) $display("FAIL rm_beat2 got %h exp 202", out_data); else n_pass++;
    set_req(2, 9'h203, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_total++; if ({out_valid, out_data, out_src, out_last} !== {1'b0, 9'd16, 2'd0, 1'b0})
      $display("FAIL rm_out got v%b d%h s%0d l%b exp v0 d010 s0 l0", out_valid, out_data, out_src, out_last); else n_pass++;
    n_total++; if ({grant, req_ready} !== 8'h00) $display("FAIL rm_grant_ready got g%b r%b exp 0", grant, req_ready); else n_pass++;
    set_req(0, 9'h0F0, 1'b1);
    tick();
    n_total++; if (grant !== 4'b0001) $display("FAIL rm_ptr_reset got %b exp 0001", grant); else n_pass++;
    tick();
    n_total++; if ({out_valid, out_data, out_src, out_last} !== {1'b1, 9'h0F0, 2'd0, 1'b1})
      $display("FAIL rm_fresh got v%b d%h s%0d l%b exp v1 d0f0 s0 l1", out_valid, out_data, out_src, out_last); else n_pass++;
    drop_req(0);
    drop_req(2);
    tick();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_max_burst();
    test_last_at_max();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
